// File: rtl/simon_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | simon_pkg: shared state encoding, default timing constants, helpers.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package simon_pkg;

   typedef enum logic [2:0] {
      S_IDLE         = 3'd0,
      S_WATCH        = 3'd1,
      S_REPLAY_GAP   = 3'd2,
      S_REPLAY_PRESS = 3'd3,
      S_WAIT_RESULT  = 3'd4,
      S_HALT         = 3'd5
   } state_t;

   localparam int unsigned IDLE_TICKS_DEF   = 50;
   localparam int unsigned GAP_TICKS_DEF    = 20;
   localparam int unsigned RESULT_TICKS_DEF = 200;
   localparam int unsigned DEPTH_DEF        = 64;
   localparam int unsigned CNT_W            = 16;

   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [1:0] onehot_to_idx(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int b = 0; b < 4; b++) begin
         if (v[b]) idx = 2'(b);
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/autoplay_seq_buf.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | autoplay_seq_buf: DEPTH x 2-bit capture store, sync write, comb read. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module autoplay_seq_buf #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [1:0]    wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [1:0]    rdata_o
);

   logic [1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/simon_autoplayer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | simon_autoplayer: watches the game's LED pattern, then replays it.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module simon_autoplayer
   import simon_pkg::*;
#(
   parameter int unsigned IDLE_TICKS   = IDLE_TICKS_DEF,
   parameter int unsigned GAP_TICKS    = GAP_TICKS_DEF,
   parameter int unsigned RESULT_TICKS = RESULT_TICKS_DEF,
   parameter int unsigned DEPTH        = DEPTH_DEF,
   parameter int unsigned AW           = $clog2(DEPTH),
   parameter int unsigned LW           = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          tick_100hz,
   input  logic          enable,
   input  logic [3:0]    game_leds,
   input  logic          led_success,
   input  logic          led_fail,
   output logic [3:0]    btn_pulse,
   output logic          busy,
   output logic [LW-1:0] seq_len,
   output logic          overflow,
   output logic          halted
);

   state_t           state_q, state_d;
   logic [LW-1:0]    seq_len_q, seq_len_d;
   logic [LW-1:0]    ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       prev_q, prev_d;
   logic             ovf_q, ovf_d;
   logic [3:0]       btn_q, btn_d;
   logic             wr_en;
   logic             capture;
   logic [1:0]       rd_idx;

   // Saturating tick count: stops at the limit so it can never wrap.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                input logic             t,
                                                input logic [CNT_W-1:0] lim);
      return (t && (c < lim)) ? c + CNT_W'(1) : c;
   endfunction

   autoplay_seq_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
      .clk     (clk),
      .we_i    (wr_en),
      .waddr_i (seq_len_q[AW-1:0]),
      .wdata_i (onehot_to_idx(game_leds)),
      .raddr_i (ptr_q[AW-1:0]),
      .rdata_o (rd_idx)
   );

   assign capture = is_onehot4(game_leds) && (game_leds != prev_q);

   always_comb begin
      state_d   = state_q;
      seq_len_d = seq_len_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      prev_d    = 4'd0;
      ovf_d     = ovf_q;
      btn_d     = 4'd0;
      wr_en     = 1'b0;
      if (!enable) begin
         state_d = S_IDLE;
         ovf_d   = 1'b0;
         ptr_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d   = S_WATCH;
               seq_len_d = '0;
               ptr_d     = '0;
               cnt_d     = '0;
            end
            S_WATCH: begin
               prev_d = game_leds;
               cnt_d  = (game_leds != 4'd0) ? '0
                        : sat_inc(cnt_q, tick_100hz, CNT_W'(IDLE_TICKS));
               if (capture) begin
                  if (seq_len_q == LW'(DEPTH)) begin
                     ovf_d   = 1'b1;
                     state_d = S_HALT;
                  end else begin
                     wr_en     = 1'b1;
                     seq_len_d = seq_len_q + LW'(1);
                  end
               end else if ((cnt_q == CNT_W'(IDLE_TICKS)) && (seq_len_q != '0)) begin
                  state_d = S_REPLAY_GAP;
                  cnt_d   = '0;
               end
            end
            S_REPLAY_GAP: begin
               if (led_fail) begin
                  state_d = S_HALT;
               end else if (cnt_q == CNT_W'(GAP_TICKS)) begin
                  state_d = S_REPLAY_PRESS;
               end else begin
                  cnt_d = sat_inc(cnt_q, tick_100hz, CNT_W'(GAP_TICKS));
               end
            end
            S_REPLAY_PRESS: begin
               if (led_fail) begin
                  state_d = S_HALT;
               end else begin
                  btn_d   = 4'b0001 << rd_idx;
                  ptr_d   = ptr_q + LW'(1);
                  cnt_d   = '0;
                  state_d = ((ptr_q + LW'(1)) < seq_len_q) ? S_REPLAY_GAP : S_WAIT_RESULT;
               end
            end
            S_WAIT_RESULT: begin
               if (led_fail) begin
                  state_d = S_HALT;
               end else if (led_success || (cnt_q == CNT_W'(RESULT_TICKS))) begin
                  state_d   = S_WATCH;
                  seq_len_d = '0;
                  ptr_d     = '0;
                  cnt_d     = '0;
               end else begin
                  cnt_d = sat_inc(cnt_q, tick_100hz, CNT_W'(RESULT_TICKS));
               end
            end
            S_HALT: begin
               state_d = S_HALT;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         seq_len_q <= '0;
         ptr_q     <= '0;
         cnt_q     <= '0;
         prev_q    <= 4'd0;
         ovf_q     <= 1'b0;
         btn_q     <= 4'd0;
      end else begin
         state_q   <= state_d;
         seq_len_q <= seq_len_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         prev_q    <= prev_d;
         ovf_q     <= ovf_d;
         btn_q     <= btn_d;
      end
   end

   assign btn_pulse = btn_q;
   assign busy      = (state_q == S_REPLAY_GAP) || (state_q == S_REPLAY_PRESS);
   assign seq_len   = seq_len_q;
   assign overflow  = ovf_q;
   assign halted    = (state_q == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_simon_autoplayer.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_simon_autoplayer: directed rounds with a press scoreboard.         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_simon_autoplayer;

   localparam int IDLE_T   = 50;
   localparam int GAP_T    = 20;
   localparam int RESULT_T = 200;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick_100hz = 1'b0;
   logic       enable = 1'b0;
   logic [3:0] game_leds = 4'd0;
   logic       led_success = 1'b0;
   logic       led_fail = 1'b0;
   logic [3:0] btn_pulse;
   logic       busy;
   logic [6:0] seq_len;
   logic       overflow;
   logic       halted;

   int checks = 0;
   int errors = 0;
   int tick_cnt = 0;
   int cyc = 0;
   logic [1:0] exp_press[$];
   int         exp_tick[$];
   logic [3:0] pat_q[$];
   logic [3:0] btn_prev = 4'd0;

   simon_autoplayer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick_100hz  (tick_100hz),
      .enable      (enable),
      .game_leds   (game_leds),
      .led_success (led_success),
      .led_fail    (led_fail),
      .btn_pulse   (btn_pulse),
      .busy        (busy),
      .seq_len     (seq_len),
      .overflow    (overflow),
      .halted      (halted)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic logic [1:0] idx_of(input logic [3:0] v);
      logic [1:0] r;
      r = 2'd0;
      for (int b = 0; b < 4; b++) if (v[b]) r = 2'(b);
      return r;
   endfunction

   // One tick strobe every fourth clock.
   initial forever begin
      @(negedge clk);
      cyc++;
      tick_100hz = ((cyc % 4) == 0);
   end

   // Per-cycle compare against the scoreboard and the always-true rules.
   initial forever begin
      @(posedge clk);
      #1;
      if (tick_100hz) tick_cnt++;
      if (btn_pulse != 4'd0) begin
         check("btn_onehot", 32'($onehot(btn_pulse)), 1);
         check("btn_single_cycle", 32'(btn_prev), 0);
         if (exp_press.size() == 0) begin
            check("unexpected_press", 32'(btn_pulse), 0);
         end else begin
            check("press_value", 32'(btn_pulse), 32'(4'b0001 << exp_press.pop_front()));
            check("press_tick", tick_cnt, exp_tick.pop_front());
         end
      end
      if (!rst_n || !enable)
         check("idle_outputs", {btn_pulse, busy, halted, overflow}, 0);
      if (halted)
         check("halt_quiet", {btn_pulse, busy}, 0);
      btn_prev = btn_pulse;
   end

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives pat_q, predicts captures from the display rules, then goes dark.
   task automatic play_round(output int n);
      logic [3:0] prev;
      prev = 4'd0;
      n = 0;
      foreach (pat_q[i]) begin
         if ($onehot(pat_q[i]) && (pat_q[i] != prev)) begin
            n++;
            exp_press.push_back(idx_of(pat_q[i]));
            exp_tick.push_back(IDLE_T + GAP_T * n);
         end
         prev = pat_q[i];
         game_leds = pat_q[i];
         clks(3);
      end
      game_leds = 4'd0;
      tick_cnt = 0;
   endtask

   task automatic wait_presses(input string name);
      int g;
      g = 0;
      while ((exp_press.size() != 0) && (g < 3000)) begin
         @(negedge clk);
         g++;
      end
      check({name, "_presses_done"}, exp_press.size(), 0);
      exp_press.delete();
      exp_tick.delete();
   endtask

   task automatic wait_ticks(input int t);
      int g;
      g = 0;
      while ((tick_cnt < t) && (g < 4 * t + 100)) begin
         @(negedge clk);
         g++;
      end
      check("tick_wait", 32'(tick_cnt >= t), 1);
   endtask

   task automatic pulse_success();
      led_success = 1'b1;
      clks(1);
      led_success = 1'b0;
      clks(2);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int g;
      // Reset
      clks(3);
      check("rst_btn", 32'(btn_pulse), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_seq_len", 32'(seq_len), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_halted", 32'(halted), 0);
      rst_n = 1'b1;
      clks(2);
      enable = 1'b1;
      clks(3);

      // Two-entry round, replay timing, result timeout
      pat_q = '{4'b0001, 4'b0000, 4'b0100};
      play_round(n);
      check("A_model_len", n, 2);
      check("A_model_tick0", exp_tick[0], 70);
      check("A_model_tick1", exp_tick[1], 90);
      check("A_seq_len", 32'(seq_len), 2);
      wait_ticks(60);
      check("A_busy_gap", 32'(busy), 1);
      wait_presses("A");
      clks(2);
      check("A_wait_busy", 32'(busy), 0);
      check("A_wait_halted", 32'(halted), 0);
      wait_ticks(90 + RESULT_T - 1);
      check("A_len_before_timeout", 32'(seq_len), 2);
      wait_ticks(90 + RESULT_T + 1);
      check("A_len_after_timeout", 32'(seq_len), 0);

      // Success starts a new round; three-entry replay order
      pat_q = '{4'b1000, 4'b0000, 4'b0010};
      play_round(n);
      wait_presses("B1");
      clks(3);
      pulse_success();
      check("B_len_cleared", 32'(seq_len), 0);
      pat_q = '{4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
      play_round(n);
      check("B_model_len", n, 3);
      check("B_seq_len", 32'(seq_len), 3);
      wait_presses("B2");
      clks(3);
      pulse_success();

      // Fail and success together: fail wins, halt holds
      pat_q = '{4'b0100};
      play_round(n);
      wait_presses("C");
      clks(3);
      led_fail = 1'b1;
      led_success = 1'b1;
      clks(1);
      led_fail = 1'b0;
      led_success = 1'b0;
      check("C_halted", 32'(halted), 1);
      check("C_len_held", 32'(seq_len), 1);
      game_leds = 4'b0001;
      clks(3);
      game_leds = 4'b0000;
      tick_cnt = 0;
      wait_ticks(100);
      check("C_still_halted", 32'(halted), 1);
      check("C_len_still", 32'(seq_len), 1);
      enable = 1'b0;
      clks(1);
      check("C_exit_halted", 32'(halted), 0);
      enable = 1'b1;
      clks(2);

      // Multi-bit displays are not captured
      game_leds = 4'b0011;
      clks(4);
      game_leds = 4'b0000;
      clks(2);
      check("D_len_0011", 32'(seq_len), 0);
      game_leds = 4'b0110;
      clks(4);
      game_leds = 4'b0000;
      clks(2);
      check("D_len_0110", 32'(seq_len), 0);
      pat_q = '{4'b0001, 4'b0000, 4'b1000};
      play_round(n);
      check("D_seq_len", 32'(seq_len), 2);
      wait_presses("D");
      clks(3);
      pulse_success();

      // Enable dropped during the gap cancels the replay
      pat_q = '{4'b0010, 4'b0000, 4'b0100};
      play_round(n);
      wait_ticks(60);
      check("E_busy_gap", 32'(busy), 1);
      enable = 1'b0;
      clks(1);
      check("E_busy_off", 32'(busy), 0);
      check("E_btn_off", 32'(btn_pulse), 0);
      exp_press.delete();
      exp_tick.delete();
      clks(120);
      enable = 1'b1;
      clks(2);

      // Asynchronous reset mid-replay
      pat_q = '{4'b0001, 4'b0000, 4'b1000};
      play_round(n);
      g = 0;
      while ((exp_press.size() > 1) && (g < 3000)) begin
         @(negedge clk);
         g++;
      end
      check("F_first_press", exp_press.size(), 1);
      clks(20);
      #3;
      rst_n = 1'b0;
      #1;
      check("F_rst_busy", 32'(busy), 0);
      check("F_rst_btn", 32'(btn_pulse), 0);
      check("F_rst_seq_len", 32'(seq_len), 0);
      check("F_rst_halted", 32'(halted), 0);
      check("F_rst_overflow", 32'(overflow), 0);
      exp_press.delete();
      exp_tick.delete();
      clks(2);
      rst_n = 1'b1;
      clks(3);

      // Overflow on the 65th capture
      for (int i = 0; i < 64; i++) begin
         game_leds = 4'b0001 << (i % 4);
         clks(2);
      end
      check("G_len_full", 32'(seq_len), 64);
      check("G_not_halted", 32'(halted), 0);
      check("G_no_overflow", 32'(overflow), 0);
      game_leds = 4'b0010;
      clks(2);
      game_leds = 4'b0000;
      check("G_overflow", 32'(overflow), 1);
      check("G_halted", 32'(halted), 1);
      check("G_len_kept", 32'(seq_len), 64);
      clks(40);
      check("G_still_halted", 32'(halted), 1);
      enable = 1'b0;
      clks(1);
      check("G_overflow_clear", 32'(overflow), 0);
      check("G_halt_clear", 32'(halted), 0);
      clks(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
